// File: rtl/demux_sched_pkg.sv
// Shared types and helpers for the round-robin demultiplexer (demux_sched).
package demux_sched_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StHold = 1'b1
  } state_e;

  localparam int unsigned CntW = 16;

  // Constant-foldable ceil(log2(v)); callers guarantee v >= 2.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: first set bit of req at or after start, circularly.
module rr_pick #(
  parameter int unsigned N     = 8,
  parameter int unsigned SEL_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  int unsigned j;

  always_comb begin
    found = 1'b0;
    idx   = start;
    j     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(start) + i;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = SEL_W'(j);
      end
    end
  end

endmodule

// File: rtl/demux_sched.sv
// One-word demultiplexer that distributes source words to N sinks in round-robin order.
// Optional ready-skipping destination search is enabled by defining DEMUX_SCHED_SKIP_EN.
module demux_sched
  import demux_sched_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned W     = 8,
  parameter int unsigned SEL_W = clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  input  logic [N-1:0]     out_ready,
  output logic [N-1:0]     out_valid,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic [CntW-1:0]  sent_cnt
);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [W-1:0]      data_q, data_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              hold;
  logic              complete;
  logic              accept;
  logic [SEL_W-1:0]  sel_inc;
  logic [SEL_W-1:0]  ptr_next;
  logic [SEL_W-1:0]  dest;

  assign hold     = (state_q == StHold);
  assign complete = hold && out_ready[sel_q];
  assign in_ready = hold ? out_ready[sel_q] : 1'b1;
  assign accept   = in_valid && in_ready;

  // Wrap against N-1 so a non-power-of-two N never produces an out-of-range index.
  assign sel_inc  = (sel_q == SEL_W'(N - 1)) ? '0 : sel_q + SEL_W'(1);
  assign ptr_next = complete ? sel_inc : ptr_q;

`ifdef DEMUX_SCHED_SKIP_EN
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;

  rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .req   (out_ready),
    .start (ptr_next),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign dest = pick_found ? pick_idx : ptr_next;
`else
  assign dest = ptr_next;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StHold;
          sel_d   = dest;
          data_d  = in_data;
        end
      end
      StHold: begin
        if (complete) begin
          ptr_d = ptr_next;
          cnt_d = cnt_q + CntW'(1);
          if (accept) begin
            sel_d  = dest;
            data_d = in_data;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    out_valid = '0;
    if (hold) out_valid[sel_q] = 1'b1;
  end

  assign busy     = hold;
  assign out_data = data_q;
  assign sel      = hold ? sel_q : ptr_q;
  assign sent_cnt = cnt_q;

endmodule

// File: tb/tb_demux_sched.sv
// Self-checking bench for demux_sched: cycle model plus directed literal checks.
module tb_demux_sched;

  localparam int N = 8;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic [N-1:0] out_ready = '0;
  logic [N-1:0] out_valid;
  logic [W-1:0] out_data;
  logic [2:0]   sel;
  logic         busy;
  logic [15:0]  sent_cnt;

  logic         in_valid5 = 1'b0;
  logic [W-1:0] in_data5 = '0;
  logic         in_ready5;
  logic [4:0]   out_ready5 = 5'h1f;
  logic [4:0]   out_valid5;
  logic [W-1:0] out_data5;
  logic [2:0]   sel5;
  logic         busy5;
  logic [15:0]  sent_cnt5;

  int n_checks = 0;
  int n_errors = 0;
  bit model_en = 1'b0;

  always #5 clk = ~clk;

  demux_sched #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .busy      (busy),
    .sent_cnt  (sent_cnt)
  );

  demux_sched #(.N(5), .W(W)) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid5),
    .in_data   (in_data5),
    .in_ready  (in_ready5),
    .out_ready (out_ready5),
    .out_valid (out_valid5),
    .out_data  (out_data5),
    .sel       (sel5),
    .busy      (busy5),
    .sent_cnt  (sent_cnt5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one held word, a rotating pointer and a transfer count.
  bit          m_held;
  int          m_ptr, m_sel, m_cnt;
  logic [W-1:0] m_data;
  bit          m_comp, m_rdy, m_acc;

  function automatic int pick(input int p, input logic [N-1:0] rdy);
`ifdef DEMUX_SCHED_SKIP_EN
    for (int i = 0; i < N; i++) if (rdy[(p + i) % N]) return (p + i) % N;
`endif
    return p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_held = 0; m_ptr = 0; m_sel = 0; m_data = '0; m_cnt = 0;
    end else begin
      m_comp = m_held && out_ready[m_sel];
      m_rdy  = m_held ? out_ready[m_sel] : 1'b1;
      m_acc  = in_valid && m_rdy;
      if (m_comp) begin
        m_ptr = (m_sel + 1) % N;
        m_cnt = (m_cnt + 1) % 65536;
      end
      if (m_acc) begin
        m_sel  = pick(m_ptr, out_ready);
        m_data = in_data;
        m_held = 1;
      end else if (m_comp) begin
        m_held = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && model_en) begin
      chk("m_out_valid", 32'(out_valid), m_held ? (32'd1 << m_sel) : 32'd0);
      chk("m_in_ready", 32'(in_ready), m_held ? 32'(out_ready[m_sel]) : 32'd1);
      chk("m_busy", 32'(busy), 32'(m_held));
      chk("m_sel", 32'(sel), m_held ? 32'(m_sel) : 32'(m_ptr));
      chk("m_out_data", 32'(out_data), 32'(m_data));
      chk("m_sent_cnt", 32'(sent_cnt), 32'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12 rst_n = 1'b1;
    model_en = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_cnt", 32'(sent_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_data", 32'(out_data), 0);

    // Continuous stream, all sinks ready: strict rotation with wrap on word 9.
    out_ready = 8'hff;
    in_valid  = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      in_data = W'(i);
      step();
      chk("stream_sel", 32'(sel), 32'((i - 1) % 8));
      chk("stream_onehot", 32'(out_valid), 32'd1 << ((i - 1) % 8));
      chk("stream_data", 32'(out_data), 32'(i));
      chk("stream_busy", 32'(busy), 1);
    end
    chk("stream_cnt8", 32'(sent_cnt), 8);
    in_valid = 1'b0;
    step();
    chk("drain_cnt", 32'(sent_cnt), 9);
    chk("drain_idle", 32'(busy), 0);
    chk("drain_ptr", 32'(sel), 1);

`ifndef DEMUX_SCHED_SKIP_EN
    // Sink 2 stalls for five cycles while holding 8'hA5.
    out_ready = 8'hfb;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    step();
    in_data = 8'ha5;
    step();
    in_data = 8'h33;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(out_valid), 32'h04);
      chk("stall_data", 32'(out_data), 32'ha5);
      chk("stall_in_ready", 32'(in_ready), 0);
      step();
    end
    out_ready = 8'hff;
    #1;
    chk("release_in_ready", 32'(in_ready), 1);
    step();
    chk("release_sel", 32'(sel), 3);
    chk("release_data", 32'(out_data), 32'h33);
    in_valid = 1'b0;
    step();
    chk("release_cnt", 32'(sent_cnt), 12);
    chk("release_ptr", 32'(sel), 4);
`else
    // Skip mode: pointer at 3 picks ready sink 5, then from 6 wraps to sink 0.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    out_ready = 8'hff;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = W'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("skip_ptr3", 32'(sel), 3);
    out_ready = 8'b0010_0001;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    step();
    chk("skip_dest5", 32'(sel), 5);
    in_data = 8'h66;
    step();
    chk("skip_dest0", 32'(sel), 0);
    in_valid = 1'b0;
    step();
`endif

    // Reset mid-hold with three completed transfers.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    out_ready = 8'hff;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = W'(i);
      step();
    end
    out_ready = 8'h00;
    in_valid  = 1'b0;
    step();
    chk("pre_rst_cnt", 32'(sent_cnt), 3);
    chk("pre_rst_valid", 32'(out_valid), 32'h08);
    #1 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 0);
    chk("async_cnt", 32'(sent_cnt), 0);
    chk("async_sel", 32'(sel), 0);
    chk("async_busy", 32'(busy), 0);
    #1 rst_n = 1'b1;
    out_ready = 8'hff;
    step();

    // N=5 instance: rotation wraps from 4 back to 0.
    in_valid5 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data5 = W'(i + 1);
      step();
      chk("n5_sel", 32'(sel5), 32'(i % 5));
      chk("n5_valid", 32'(out_valid5), 32'd1 << (i % 5));
    end
    in_valid5 = 1'b0;
    step();
    chk("n5_cnt", 32'(sent_cnt5), 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/demux_sched.md
DEMUX_SCHED -- requirements
Module: demux_sched

Interface
REQ-001 Parameter N, default 8, number of sinks (2..16).
REQ-002 Parameter W, default 8, data word width.
REQ-003 Constant SEL_W = clog2(N), used as the width of the sink index.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  source presents a word.
REQ-008 in_data  input  W  source word.
REQ-009 in_ready  output  1  block accepts the word this cycle.
REQ-010 out_ready  input  N  per-sink ready, one bit per sink.
REQ-011 out_valid  output  N  one-hot demux of the held word's valid; all zero when nothing is held.
REQ-012 out_data  output  W  held word, shared by all sinks.
REQ-013 sel  output  SEL_W  destination index of the held word, or the next pointer when IDLE.
REQ-014 busy  output  1  high in HOLD.
REQ-015 sent_cnt  output  16  count of completed sink transfers.

Function
REQ-016 FSM states: IDLE and HOLD.
REQ-017 IDLE: in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-018 Accept occurs when in_valid && in_ready; at that edge in_data latches, the destination latches into sel, and the state becomes HOLD.
REQ-019 HOLD: out_valid[sel] SHALL be 1, every other out_valid bit 0, and out_data and sel stable until completion.
REQ-020 Completion occurs in HOLD when out_ready[sel] is 1; at that edge the round-robin pointer SHALL become sel+1, wrapping from N-1 to 0, and sent_cnt SHALL increment, wrapping 16'hFFFF to 0.
REQ-021 In HOLD, in_ready = out_ready[sel], so a new accept can occur in the completion cycle.
REQ-022 A simultaneous completion and accept SHALL leave the block in HOLD with the new word, and its destination is chosen from the updated pointer.
REQ-023 Completion without an accept SHALL return the block to IDLE.
REQ-024 Latency: a word accepted at edge k SHALL be offered (out_valid) from cycle k+1, giving a throughput of 1 word per cycle when sinks are ready.
REQ-025 Without DEMUX_SCHED_SKIP_EN, the destination at accept SHALL equal the pointer (strict rotation), and the block waits on a non-ready sink indefinitely.
REQ-026 Out-of-range indices (pointer >= N when N is not a power of 2) SHALL never occur, because the wrap compares against N-1.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, pointer 0, sel 0, out_valid 0, out_data 0, sent_cnt 0 and busy 0; in_ready then follows IDLE (1) once rst_n is high.
REQ-028 Reset asserted during HOLD SHALL drop the held word without counting it.
REQ-029 The first accept after reset SHALL target sink 0, or with skip enabled the first ready sink at or after 0.

Configuration
REQ-030 With macro DEMUX_SCHED_SKIP_EN defined, the destination at accept SHALL be the first index at or after the pointer (circularly) whose out_ready is 1; if none is ready it SHALL be the pointer.
REQ-031 With DEMUX_SCHED_SKIP_EN undefined, the behaviour of REQ-025 applies and no search logic is synthesized.

Structure
REQ-032 Shared package demux_sched_pkg SHALL hold the state encoding (IDLE=0, HOLD=1), the sent_cnt width constant 16, and a clog2 function.
REQ-033 Sub-module rr_pick (combinational rotating-priority search over N bits from a start index, output index and found flag) SHALL be instantiated only under DEMUX_SCHED_SKIP_EN.
REQ-034 out_valid SHALL be generated by decoding sel gated with busy, and by no other means.

Verification
REQ-035 Reset then out_ready=8'hFF with continuous in_valid of data 1..8 -> sel sequence 0..7, each out_valid one-hot, sent_cnt=8, and sel=0 (wrapped) for word 9.
REQ-036 Hold out_ready[2]=0 for 5 cycles with word 8'hA5 destined for sink 2 -> out_valid=8'h04 stable, out_data=8'hA5 stable, in_ready=0; completion in the cycle out_ready[2] rises.
REQ-037 Back-to-back traffic with all sinks ready -> one completion per cycle, busy stays 1, and no IDLE cycle occurs between words.
REQ-038 With DEMUX_SCHED_SKIP_EN, pointer=3 and out_ready=8'b0010_0001 -> destination 5, then with the pointer at 6 the next destination is 0.
REQ-039 Assert rst_n=0 mid-HOLD with sent_cnt=3 -> out_valid=0, sent_cnt=0 and sel=0 immediately, without waiting for a clock edge.
REQ-040 N=5, with all sinks ready for 6 words -> sel sequence 0,1,2,3,4,0.
